ks_sum_stage: RTL and testbench

- Post-processing end of the 16-bit Kogge-Stone prefix chain. It consumes the final prefix-stage outputs: carry-in, saved propagate vector and resolved group-generate vector.
- It forms the registered sum, carry-out and status flags.
- It adds a valid/ready handshake with a 2-entry skid buffer, so the combinational prefix network can feed a stallable downstream consumer (ALU writeback).

---
 rtl/ks_pkg.sv | 26 ++
 rtl/ks_skid_buf.sv | 66 ++++++
 rtl/ks_sum_stage.sv | 68 ++++++
 tb/tb_ks_sum_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared widths, flag positions, skid-buffer state encoding and result payload
// for the Kogge-Stone sum stage.
package ks_pkg;

    localparam int unsigned KS_W  = 16;
    localparam int unsigned FLG_W = 4;

    localparam int unsigned FLG_COUT = 0;
    localparam int unsigned FLG_ZERO = 1;
    localparam int unsigned FLG_NEG  = 2;
    localparam int unsigned FLG_OVF  = 3;

    // Encoded as {out_v, skd_v}; 2'b01 is unreachable
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } skid_state_e;

    typedef struct packed {
        logic [KS_W-1:0]  sum;
        logic             cout;
        logic [FLG_W-1:0] flags;
    } ks_arith_t;

endpackage

// File: rtl/ks_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The downstream side is driven only
// from the output register; the skid register absorbs the one transfer that
// arrives in the cycle a stall is first seen.
module ks_skid_buf
    import ks_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    skid_state_e  state;
    logic [W-1:0] out_q;
    logic [W-1:0] skd_q;
    logic         acc;
    logic         drn;

    assign up_ready = !rst && !state[0];
    assign dn_valid = state[1];
    assign dn_data  = out_q;
    assign acc      = up_valid && up_ready;
    assign drn      = dn_valid && dn_ready;

    // Occupancy state and payload registers; data only loads on an accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            out_q <= '0;
            skd_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        out_q <= up_data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        out_q <= up_data;
                    end else if (acc) begin
                        skd_q <= up_data;
                        state <= FULL;
                    end else if (drn) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drn) begin
                        out_q <= skd_q;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ks_sum_stage.sv
// Final stage of the 16-bit Kogge-Stone adder: forms sum, carry-out and
// status flags from the prefix outputs and presents them through a skid
// buffer so the downstream writeback can stall.
module ks_sum_stage
    import ks_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_c0,
    input  logic [KS_W-1:0]   i_p_save,
    input  logic [KS_W-1:0]   i_gk,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [KS_W-1:0]   o_sum,
    output logic              o_cout,
    output logic [FLG_W-1:0]  o_flags,
    output logic [TAG_W-1:0]  o_tag
);

    typedef struct packed {
        ks_arith_t        arith;
        logic [TAG_W-1:0] tag;
    } ks_result_t;

    localparam int unsigned RES_W = $bits(ks_result_t);

    logic [KS_W-1:0] carry_in;
    ks_result_t      res_d;
    ks_result_t      res_q;

    assign carry_in = {i_gk[KS_W-2:0], i_c0};

    // Sum bits and flags from the resolved carries
    always_comb begin
        res_d                       = '0;
        res_d.arith.sum             = i_p_save ^ carry_in;
        res_d.arith.cout            = i_gk[KS_W-1];
        res_d.arith.flags[FLG_COUT] = i_gk[KS_W-1];
        res_d.arith.flags[FLG_ZERO] = (res_d.arith.sum == '0);
        res_d.arith.flags[FLG_NEG]  = res_d.arith.sum[KS_W-1];
        res_d.arith.flags[FLG_OVF]  = i_gk[KS_W-2] ^ i_gk[KS_W-1];
        res_d.tag                   = i_tag;
    end

    ks_skid_buf #(
        .W (RES_W)
    ) u_skid (
        .clk      (i_clk),
        .rst      (i_rst),
        .up_valid (i_valid),
        .up_ready (o_ready),
        .up_data  (res_d),
        .dn_valid (o_valid),
        .dn_ready (i_ready),
        .dn_data  (res_q)
    );

    assign o_sum   = res_q.arith.sum;
    assign o_cout  = res_q.arith.cout;
    assign o_flags = res_q.arith.flags;
    assign o_tag   = res_q.tag;

endmodule

// File: tb/tb_ks_sum_stage.sv
// Directed and randomised checks of the Kogge-Stone sum stage and its skid buffer.
module tb_ks_sum_stage;

    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic             i_c0;
    logic [15:0]      i_p_save;
    logic [15:0]      i_gk;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [15:0]      o_sum;
    logic             o_cout;
    logic [3:0]       o_flags;
    logic [TAG_W-1:0] o_tag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ks_sum_stage #(.TAG_W(TAG_W)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_c0     (i_c0),
        .i_p_save (i_p_save),
        .i_gk     (i_gk),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_cout   (o_cout),
        .o_flags  (o_flags),
        .o_tag    (o_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference ripple carry chain producing the group-generate vector
    function automatic logic [15:0] gk_of(input logic [15:0] a, input logic [15:0] b, input logic c0);
        logic        c;
        logic [15:0] g;
        c = c0;
        for (int k = 0; k < 16; k++) begin
            c    = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
            g[k] = c;
        end
        return g;
    endfunction

    // Expected {sum, cout, flags, tag} from plain integer addition
    function automatic logic [24:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c0, input logic [3:0] tag);
        logic [16:0] s;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b} + 17'(c0);
        ovf = (a[15] == b[15]) && (s[15] != a[15]);
        return {s[15:0], s[16], ovf, s[15], (s[15:0] == 16'h0000), s[16], tag};
    endfunction

    function automatic logic [24:0] out_word();
        return {o_sum, o_cout, o_flags, o_tag};
    endfunction

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic c0, input logic [3:0] tag);
        i_valid  = 1'b1;
        i_p_save = a ^ b;
        i_gk     = gk_of(a, b, c0);
        i_c0     = c0;
        i_tag    = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [24:0] q[$];
        logic [24:0] cur_exp;
        logic [24:0] held;
        logic        held_pending;
        logic        acc_flag;
        int          sent;
        int          cyc;
        logic [15:0] ra, rb;
        logic        rc;
        logic [3:0]  rt;

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_c0 = 1'b0; i_p_save = '0; i_gk = '0; i_tag = '0;
        step();
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum",   32'(o_sum),   32'd0);
        step();
        i_rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);

        // Basic add
        i_ready = 1'b1;
        set_op(16'h1234, 16'h0001, 1'b0, 4'd1);
        step();
        i_valid = 1'b0;
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_sum",   32'(o_sum),   32'h1235);
        check("t1_cout",  32'(o_cout),  32'd0);
        check("t1_flags", 32'(o_flags), 32'h0);
        check("t1_tag",   32'(o_tag),   32'd1);

        // Carry out to zero, then signed overflow
        set_op(16'hFFFF, 16'h0001, 1'b0, 4'd2);
        step();
        check("t2a_sum",   32'(o_sum),   32'h0000);
        check("t2a_cout",  32'(o_cout),  32'd1);
        check("t2a_flags", 32'(o_flags), 32'h3);
        set_op(16'h7FFF, 16'h0001, 1'b0, 4'd3);
        step();
        i_valid = 1'b0;
        check("t2b_sum",   32'(o_sum),   32'h8000);
        check("t2b_flags", 32'(o_flags), 32'hC);
        step();
        check("t2_idle_valid", 32'(o_valid), 32'd0);

        // Carry-in only, then negative overflow wrapping to zero
        set_op(16'h0000, 16'h0000, 1'b1, 4'd4);
        step();
        check("t6a_sum",   32'(o_sum),   32'h0001);
        check("t6a_flags", 32'(o_flags), 32'h0);
        set_op(16'h8000, 16'h8000, 1'b0, 4'd5);
        step();
        i_valid = 1'b0;
        check("t6b_sum",   32'(o_sum),   32'h0000);
        check("t6b_cout",  32'(o_cout),  32'd1);
        check("t6b_flags", 32'(o_flags), 32'hB);
        step();

        // Stall with three back-to-back operations
        i_ready = 1'b0;
        set_op(16'h0010, 16'h0020, 1'b0, 4'd1);
        step();
        check("t3_tag1",    32'(o_tag),   32'd1);
        check("t3_ready1",  32'(o_ready), 32'd1);
        set_op(16'h1000, 16'h0100, 1'b0, 4'd2);
        step();
        check("t3_full_ready", 32'(o_ready), 32'd0);
        check("t3_hold_tag",   32'(o_tag),   32'd1);
        set_op(16'hAAAA, 16'h5555, 1'b1, 4'd3);
        step();
        check("t3_blocked_ready", 32'(o_ready), 32'd0);
        check("t3_stall_tag",     32'(o_tag),   32'd1);
        step();
        check("t3_stall_sum",     32'(o_sum),   32'h0030);
        i_ready = 1'b1;
        step();
        check("t3_out2_tag",  32'(o_tag),   32'd2);
        check("t3_out2_sum",  32'(o_sum),   32'h1100);
        check("t3_out2_ready", 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        check("t3_out3_tag",   32'(o_tag),   32'd3);
        check("t3_out3_sum",   32'(o_sum),   32'h0000);
        check("t3_out3_flags", 32'(o_flags), 32'h3);
        step();
        check("t3_empty", 32'(o_valid), 32'd0);

        // Reset while full
        i_ready = 1'b0;
        set_op(16'h0001, 16'h0001, 1'b0, 4'd6);
        step();
        set_op(16'h0003, 16'h0004, 1'b0, 4'd7);
        step();
        i_valid = 1'b0;
        check("t5_full_ready", 32'(o_ready), 32'd0);
        i_rst = 1'b1;
        step();
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_word",  32'(out_word()), 32'd0);
        check("t5_rst_ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        #1;
        check("t5_ready_after", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_stale", 32'(o_valid), 32'd0);
        end

        // Randomised traffic against a scoreboard
        sent = 0; cyc = 0; held_pending = 1'b0; held = '0; cur_exp = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            acc_flag = i_valid && o_ready;
            if (acc_flag) begin
                q.push_back(cur_exp);
                sent++;
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) check("rnd_extra_out", 32'(q.size()), 32'd1);
                else check("rnd_order", 32'(out_word()), 32'(q.pop_front()));
            end
            if (held_pending && o_valid) check("rnd_stable", 32'(out_word()), 32'(held));
            held_pending = o_valid && !i_ready;
            held         = out_word();
            @(posedge clk);
            #1;
            if (!i_valid || acc_flag) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom);
                    rt = 4'($urandom);
                    set_op(ra, rb, rc, rt);
                    cur_exp = model(ra, rb, rc, rt);
                end else begin
                    i_valid = 1'b0;
                end
            end
            i_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("rnd_sent",  32'(sent),     32'd1000);
        check("rnd_drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
